// File: rtl/card_dealer_if.sv
// Request/response bundle between the round controller and the card dealer.
// The master drives the requests, and the dealer (slave) returns the hands and status.
interface card_dealer_if #(
  parameter int unsigned CARD_W = 4
);
  logic              start;
  logic              draw_p3;
  logic              draw_d3;
  logic              stand;
  logic [CARD_W-1:0] pcard1;
  logic [CARD_W-1:0] pcard2;
  logic [CARD_W-1:0] pcard3;
  logic [CARD_W-1:0] dcard1;
  logic [CARD_W-1:0] dcard2;
  logic [CARD_W-1:0] dcard3;
  logic              busy;
  logic              ready3;
  logic              done;

  modport master (
    output start, draw_p3, draw_d3, stand,
    input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, busy, ready3, done
  );

  modport slave (
    input  start, draw_p3, draw_d3, stand,
    output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, busy, ready3, done
  );
endinterface

// File: rtl/card_dealer.sv
// Card source and deal sequencer. A free-running 1..NUM_CARDS counter is sampled into
// the player/banker hand registers: an opening deal of P1,D1,P2,D2, then third cards on request.
module card_dealer #(
  parameter int unsigned NUM_CARDS = 13,
  parameter int unsigned CARD_W    = 4
) (
  input  logic          slow_clock,
  input  logic          resetb,
  card_dealer_if.slave  dealer_io
);

  typedef enum logic [3:0] {
    StIdle, StDealP1, StDealD1, StDealP2, StDealD2, StWait3, StDealP3, StDealD3, StDone
  } state_e;

  // Hand slots: 0=P1 1=D1 2=P2 3=D2 4=P3 5=D3
  state_e            state_q, state_d;
  logic [CARD_W-1:0] cnt_q, cnt_d;
  logic [CARD_W-1:0] hand_q [6];
  logic [CARD_W-1:0] hand_d [6];
  logic              pend_p3_q, pend_p3_d;
  logic              pend_d3_q, pend_d3_d;
  logic              pend_st_q, pend_st_d;
  logic              busy_q, ready3_q, done_q;
  logic              accept, p3_taken, d3_taken;

  assign cnt_d = (cnt_q == CARD_W'(NUM_CARDS)) ? CARD_W'(1) : cnt_q + CARD_W'(1);

  always_comb begin
    state_d = state_q;
    hand_d  = hand_q;
    accept   = (state_q == StWait3) || (state_q == StDealP3) || (state_q == StDealD3);
    // A card counts as taken while its deal cycle is in progress, so repeat draws drop.
    p3_taken = (hand_q[4] != '0) || (state_q == StDealP3);
    d3_taken = (hand_q[5] != '0) || (state_q == StDealD3);
    pend_p3_d = (pend_p3_q | (accept & dealer_io.draw_p3)) & ~p3_taken;
    pend_d3_d = (pend_d3_q | (accept & dealer_io.draw_d3)) & ~d3_taken;
    pend_st_d = pend_st_q | (accept & dealer_io.stand);

    unique case (state_q)
      StIdle, StDone: begin
        if (dealer_io.start) begin
          state_d = StDealP1;
          for (int i = 0; i < 6; i++) hand_d[i] = '0;
        end
      end
      StDealP1: begin
        hand_d[0] = cnt_q;
        state_d   = StDealD1;
      end
      StDealD1: begin
        hand_d[1] = cnt_q;
        state_d   = StDealP2;
      end
      StDealP2: begin
        hand_d[2] = cnt_q;
        state_d   = StDealD2;
      end
      StDealD2: begin
        hand_d[3] = cnt_q;
        state_d   = StWait3;
      end
      StWait3: begin
        if (pend_p3_d)      state_d = StDealP3;
        else if (pend_d3_d) state_d = StDealD3;
        else if (pend_st_d) state_d = StDone;
      end
      StDealP3: begin
        hand_d[4] = cnt_q;
        if (d3_taken)       state_d = StDone;
        else if (pend_d3_d) state_d = StDealD3;
        else                state_d = StWait3;
      end
      StDealD3: begin
        hand_d[5] = cnt_q;
        if (p3_taken)       state_d = StDone;
        else if (pend_p3_d) state_d = StDealP3;
        else                state_d = StWait3;
      end
      default: state_d = StIdle;
    endcase

    // The round is over, so nothing left pending carries into the next one.
    if (state_d == StDone) begin
      pend_p3_d = 1'b0;
      pend_d3_d = 1'b0;
      pend_st_d = 1'b0;
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= StIdle;
      cnt_q     <= CARD_W'(1);
      for (int i = 0; i < 6; i++) hand_q[i] <= '0;
      pend_p3_q <= 1'b0;
      pend_d3_q <= 1'b0;
      pend_st_q <= 1'b0;
      busy_q    <= 1'b0;
      ready3_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hand_q    <= hand_d;
      pend_p3_q <= pend_p3_d;
      pend_d3_q <= pend_d3_d;
      pend_st_q <= pend_st_d;
      busy_q    <= (state_d != StIdle) && (state_d != StWait3) && (state_d != StDone);
      ready3_q  <= (state_d == StWait3) && !(pend_p3_d || pend_d3_d || pend_st_d);
      done_q    <= (state_d == StDone);
    end
  end

  assign dealer_io.pcard1 = hand_q[0];
  assign dealer_io.dcard1 = hand_q[1];
  assign dealer_io.pcard2 = hand_q[2];
  assign dealer_io.dcard2 = hand_q[3];
  assign dealer_io.pcard3 = hand_q[4];
  assign dealer_io.dcard3 = hand_q[5];
  assign dealer_io.busy   = busy_q;
  assign dealer_io.ready3 = ready3_q;
  assign dealer_io.done   = done_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer. It covers the opening deal, wrapping of the card counter,
// the third-card draws, stand, the ignored requests, and an abort by reset part-way through a round.
module tb_card_dealer;
  logic slow_clock = 1'b0;
  logic resetb     = 1'b0;
  int   errors     = 0;
  int   checks     = 0;

  card_dealer_if #(.CARD_W(4)) bus ();

  card_dealer #(.NUM_CARDS(13), .CARD_W(4)) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .dealer_io  (bus.slave)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic step();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cards(input string tag, input int p1, input int d1, input int p2,
                           input int d2, input int p3, input int d3);
    chk({tag, ".pcard1"}, 32'(bus.pcard1), p1);
    chk({tag, ".dcard1"}, 32'(bus.dcard1), d1);
    chk({tag, ".pcard2"}, 32'(bus.pcard2), p2);
    chk({tag, ".dcard2"}, 32'(bus.dcard2), d2);
    chk({tag, ".pcard3"}, 32'(bus.pcard3), p3);
    chk({tag, ".dcard3"}, 32'(bus.dcard3), d3);
  endtask

  task automatic chk_flags(input string tag, input int b, input int r, input int d);
    chk({tag, ".busy"},   32'(bus.busy),   b);
    chk({tag, ".ready3"}, 32'(bus.ready3), r);
    chk({tag, ".done"},   32'(bus.done),   d);
  endtask

  initial begin
    bus.start = 1'b0; bus.draw_p3 = 1'b0; bus.draw_d3 = 1'b0; bus.stand = 1'b0;
    step(); step();
    chk_cards("reset", 0, 0, 0, 0, 0, 0);
    chk_flags("reset", 0, 0, 0);

    // Opening deal with start in the first cycle (counter=1)
    resetb = 1'b1; bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk_flags("p1_state", 1, 0, 0);
    chk("p1_not_yet", 32'(bus.pcard1), 0);
    step();
    chk("d1_state.pcard1", 32'(bus.pcard1), 2);
    step(); step();
    chk("d2_state.pcard2", 32'(bus.pcard2), 4);
    chk("d2_state.dcard2", 32'(bus.dcard2), 0);
    step();
    chk_cards("open1", 2, 3, 4, 5, 0, 0);
    chk_flags("open1", 0, 1, 0);

    // Simultaneous draws at counter=7
    step();
    bus.draw_p3 = 1'b1; bus.draw_d3 = 1'b1;
    step(); bus.draw_p3 = 1'b0; bus.draw_d3 = 1'b0;
    chk_flags("dealp3", 1, 0, 0);
    step();
    chk("dealp3.pcard3", 32'(bus.pcard3), 8);
    chk("dealp3.dcard3", 32'(bus.dcard3), 0);
    step();
    chk_cards("both3", 2, 3, 4, 5, 8, 9);
    chk_flags("both3", 0, 0, 1);

    // New round from DONE at counter=11 with the counter wrapping; start during P2 is ignored
    step();
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk_cards("clear2", 0, 0, 0, 0, 0, 0);
    chk_flags("clear2", 1, 0, 0);
    step();
    chk("r2.pcard1", 32'(bus.pcard1), 12);
    step();
    chk("r2.dcard1", 32'(bus.dcard1), 13);
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk("r2.pcard2", 32'(bus.pcard2), 1);
    chk("r2.busy_mid", 32'(bus.busy), 1);
    step();
    chk_cards("open2", 12, 13, 1, 2, 0, 0);
    chk_flags("open2", 0, 1, 0);

    // Stand alone, then a draw in DONE is ignored
    bus.stand = 1'b1;
    step(); bus.stand = 1'b0;
    chk_cards("stand", 12, 13, 1, 2, 0, 0);
    chk_flags("stand", 0, 0, 1);
    bus.draw_p3 = 1'b1;
    step(); bus.draw_p3 = 1'b0;
    chk("done_draw.pcard3", 32'(bus.pcard3), 0);
    chk_flags("done_draw", 0, 0, 1);

    // Restart at counter=5, then abort by reset during DEAL_D1
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    chk_cards("clear3", 0, 0, 0, 0, 0, 0);
    step();
    chk("r3.pcard1", 32'(bus.pcard1), 6);
    resetb = 1'b0;
    #1;
    chk_cards("abort", 0, 0, 0, 0, 0, 0);
    chk_flags("abort", 0, 0, 0);
    step();
    resetb = 1'b1; bus.draw_p3 = 1'b1;
    step(); bus.draw_p3 = 1'b0;
    chk("idle_draw.pcard3", 32'(bus.pcard3), 0);
    chk_flags("idle_draw", 0, 0, 0);
    bus.start = 1'b1;
    step(); bus.start = 1'b0;
    repeat (4) step();
    chk_cards("open4", 3, 4, 5, 6, 0, 0);
    chk_flags("open4", 0, 1, 0);

    // Banker-only draw, a repeated banker draw is dropped, then the player draw finishes the round
    bus.draw_d3 = 1'b1;
    step(); bus.draw_d3 = 1'b0;
    step();
    chk("d3only.dcard3", 32'(bus.dcard3), 8);
    chk("d3only.pcard3", 32'(bus.pcard3), 0);
    chk_flags("d3only", 0, 1, 0);
    bus.draw_d3 = 1'b1;
    step(); bus.draw_d3 = 1'b0;
    chk("repeat_d3.dcard3", 32'(bus.dcard3), 8);
    chk_flags("repeat_d3", 0, 1, 0);
    bus.draw_p3 = 1'b1;
    step(); bus.draw_p3 = 1'b0;
    step();
    chk_cards("final", 3, 4, 5, 6, 11, 8);
    chk_flags("final", 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
